spi_master_ctrl: RTL and testbench

Transfer sequencer for the SPI master datapath. It sits directly upstream of the 8-bit SPI shift register and drives that register's load_enable, shift_enable, shift_clk, shift_clear and serial_in controls. It generates SCK and SS_n from the system clock and supports all four CPOL/CPHA modes. MOSI is the shift register's serial_out, routed externally. This block only times SCK edges and samples MISO.

---
 rtl/spi_master_ctrl_if.sv | 37 +++
 rtl/spi_master_ctrl.sv | 131 +++++++++++++
 tb/tb_spi_master_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_master_ctrl_if : control/status bundle for spi_master_ctrl   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface spi_master_ctrl_if #(
   parameter int DIV_WIDTH = 8
);
   logic                 start;
   logic                 abort;
   logic                 cpol;
   logic                 cpha;
   logic [DIV_WIDTH-1:0] clk_div;
   logic                 miso;
   logic                 busy;
   logic                 done;
   logic                 load_enable;
   logic                 shift_enable;
   logic                 shift_clk;
   logic                 shift_clear;
   logic                 serial_in;
   logic                 sck;
   logic                 ss_n;

   modport master (
      input  start, abort, cpol, cpha, clk_div, miso,
      output busy, done, load_enable, shift_enable, shift_clk, shift_clear,
             serial_in, sck, ss_n
   );

   modport slave (
      output start, abort, cpol, cpha, clk_div, miso,
      input  busy, done, load_enable, shift_enable, shift_clk, shift_clear,
             serial_in, sck, ss_n
   );
endinterface
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spi_master_ctrl : SPI transfer sequencer, SCK/SS_n and MISO      |
// | sampling for an external 8-bit shift register. Revision 1.0      |
// +------------------------------------------------------------------+
module spi_master_ctrl #(
   parameter int NUM_BITS  = 8,
   parameter int DIV_WIDTH = 8
) (
   input  wire logic         clk,
   input  wire logic         n_rst,
   spi_master_ctrl_if.master bus
);
   localparam int EDGES = 2 * NUM_BITS;
   localparam int EW    = $clog2(EDGES + 1);
   localparam logic [EW-1:0]        LAST_EDGE = EW'(EDGES - 1);
   localparam logic [EW-1:0]        EDGE_ONE  = EW'(1);
   localparam logic [DIV_WIDTH-1:0] CNT_ONE   = DIV_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SETUP = 3'd2,
      XFER  = 3'd3,
      HOLD  = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_cpol;
   logic                 r_cpha;
   logic [DIV_WIDTH-1:0] r_div;
   logic [DIV_WIDTH-1:0] r_cnt;
   logic [EW-1:0]        r_edge;
   logic                 r_sck;
   logic                 r_serial_in;
   logic                 r_shift_clk;
   logic                 r_shift_clear;
   logic                 w_toggle;
   logic                 w_tick;
   logic                 w_active;
   logic                 w_abort;
   logic                 w_launch;
   logic                 w_sample;

   // Counter compares against D itself so an all-ones divider cannot overflow.
   assign w_tick   = (r_cnt == r_div);
   assign w_active = (r_state == SETUP) || (r_state == XFER) || (r_state == HOLD);
   assign w_abort  = bus.abort && (r_state != IDLE);
   assign w_launch = bus.start && !bus.abort && (r_state == IDLE);
   // r_edge holds edges already made, so the upcoming edge is odd when r_edge is even.
   assign w_sample = w_toggle && (r_edge[0] == r_cpha);

   always_comb begin
      w_state_nxt = r_state;
      w_toggle    = 1'b0;
      case (r_state)
         IDLE:  if (w_launch) w_state_nxt = LOAD;
         LOAD:  w_state_nxt = SETUP;
         SETUP: begin
            if (w_tick) begin
               w_toggle    = 1'b1;
               w_state_nxt = XFER;
            end
         end
         XFER: begin
            if (w_tick) begin
               w_toggle = 1'b1;
               if (r_edge == LAST_EDGE) w_state_nxt = HOLD;
            end
         end
         HOLD:    if (w_tick) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (w_abort) begin
         w_state_nxt = IDLE;
         w_toggle    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         r_state       <= IDLE;
         r_cpol        <= 1'b0;
         r_cpha        <= 1'b0;
         r_div         <= '0;
         r_cnt         <= '0;
         r_edge        <= '0;
         r_sck         <= 1'b0;
         r_serial_in   <= 1'b0;
         r_shift_clk   <= 1'b0;
         r_shift_clear <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_shift_clk   <= w_sample;
         r_shift_clear <= w_abort;

         if (w_launch) begin
            r_cpol  <= bus.cpol;
            r_cpha  <= bus.cpha;
            r_div   <= bus.clk_div;
            r_sck   <= bus.cpol;
         end else if (w_abort) begin
            r_sck   <= r_cpol;
         end else if (w_toggle) begin
            r_sck   <= ~r_sck;
         end

         if (w_sample) r_serial_in <= bus.miso;

         if (w_active && !w_tick && !w_abort) r_cnt <= r_cnt + CNT_ONE;
         else                                 r_cnt <= '0;

         if (r_state == LOAD) r_edge <= '0;
         else if (w_toggle)   r_edge <= r_edge + EDGE_ONE;
      end
   end

   assign bus.busy         = (r_state == LOAD) || w_active;
   assign bus.ss_n         = !bus.busy;
   assign bus.done         = (r_state == DONE);
   assign bus.load_enable  = (r_state == LOAD);
   assign bus.shift_enable = w_active;
   assign bus.shift_clk    = r_shift_clk;
   assign bus.shift_clear  = r_shift_clear;
   assign bus.serial_in    = r_serial_in;
   assign bus.sck          = r_sck;
endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_spi_master_ctrl : bench for spi_master_ctrl with shift        |
// | register and SPI slave models. Revision 1.0                      |
// +------------------------------------------------------------------+
module tb_spi_master_ctrl;
   localparam int NB = 8;
   localparam int DW = 8;

   typedef struct {
      logic          cpol;
      logic          cpha;
      logic [DW-1:0] div;
      logic [NB-1:0] load;
      logic [NB-1:0] pat;
      logic          loop;
      logic [NB-1:0] exp_res;
      int            exp_busy;
   } vec_t;

   typedef struct {
      logic [NB-1:0] res;
      int            busy;
      logic [NB-1:0] rx;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   spi_master_ctrl_if #(.DIV_WIDTH(DW)) bus();
   spi_master_ctrl #(.NUM_BITS(NB), .DIV_WIDTH(DW)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];
   vec_t vecs[6];

   logic [NB-1:0] sr, load_val, slv_pat, rx;
   logic          mosi, slv_bit, loopback, cur_cpol, cur_cpha, prev_sck, prev_busy;
   int            cur_div, edges, edge_total, busy_cnt, shift_cnt, load_cnt;
   int            bad_gap, excl_bad, cyc, last_edge;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Downstream shift register: MSB is MOSI, serial_in enters at the LSB.
   always @(posedge clk) begin
      if (!n_rst)                                 sr <= '0;
      else if (bus.shift_clear)                   sr <= '0;
      else if (bus.load_enable)                   sr <= load_val;
      else if (bus.shift_enable && bus.shift_clk) sr <= {sr[NB-2:0], bus.serial_in};
   end
   assign mosi     = sr[NB-1];
   assign bus.miso = loopback ? mosi : slv_bit;

   // Slave model, transfer statistics and scoreboard consumer.
   always @(negedge clk) begin
      int idx;
      exp_t e;
      cyc++;
      if (int'(bus.load_enable) + int'(bus.shift_clk) + int'(bus.shift_clear) > 1) excl_bad++;
      if (bus.busy && !prev_busy) begin
         busy_cnt = 0; shift_cnt = 0; load_cnt = 0; bad_gap = 0; edge_total = 0; rx = '0;
      end
      prev_busy = bus.busy;
      if (bus.busy)        busy_cnt++;
      if (bus.shift_clk)   shift_cnt++;
      if (bus.load_enable) load_cnt++;
      if (bus.ss_n) begin
         edges    = 0;
         prev_sck = cur_cpol;
      end else if (bus.sck != prev_sck) begin
         edges++;
         edge_total++;
         prev_sck = bus.sck;
         if (edges > 1 && (cyc - last_edge) != cur_div + 1) bad_gap++;
         last_edge = cyc;
         if (((edges % 2) == 1) == (cur_cpha == 1'b0)) rx = {rx[NB-2:0], mosi};
      end
      idx = cur_cpha ? ((edges + 1) / 2 - 1) : (edges / 2);
      if (idx < 0)      idx = 0;
      if (idx > NB - 1) idx = NB - 1;
      slv_bit = slv_pat[NB-1-idx];
      if (bus.done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("result", sr, e.res);
            check("busy_cycles", busy_cnt, e.busy);
            check("shift_pulses", shift_cnt, NB);
            check("sck_edges", edge_total, 2 * NB);
            check("mosi_seq", rx, e.rx);
            check("half_period", bad_gap, 0);
            check("load_pulses", load_cnt, 1);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_mode(input vec_t v);
      cur_cpol = v.cpol; cur_cpha = v.cpha; cur_div = int'(v.div);
      load_val = v.load; slv_pat = v.pat; loopback = v.loop;
      bus.cpol = v.cpol; bus.cpha = v.cpha; bus.clk_div = v.div;
      tick();
   endtask

   task automatic wait_edges(input int n);
      bit ok = 1'b0;
      for (int i = 0; i < 5000 && !ok; i++) begin
         tick();
         if (edges >= n) ok = 1'b1;
      end
      check("edge_wait", ok, 1);
   endtask

   task automatic run_vector(input vec_t v, input bit poke);
      exp_t e;
      bit seen = 1'b0;
      set_mode(v);
      e.res = v.exp_res; e.busy = v.exp_busy; e.rx = v.load;
      exp_q.push_back(e);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      if (poke) begin
         wait_edges(6);
         bus.start = 1'b1; tick(); bus.start = 1'b0;
      end
      for (int i = 0; i < 6000 && !seen; i++) begin
         tick();
         if (bus.done) seen = 1'b1;
      end
      check("done_seen", seen, 1);
      tick();
      check("idle_sck", bus.sck, v.cpol);
      check("idle_ss_n", bus.ss_n, 1);
      check("idle_busy_done", {bus.busy, bus.done}, 0);
   endtask

   function automatic logic [8:0] outs();
      return {bus.busy, bus.done, bus.load_enable, bus.shift_enable, bus.shift_clk,
              bus.shift_clear, bus.serial_in, bus.sck, bus.ss_n};
   endfunction

   initial begin
      vec_t v;
      int   seen;
      //          cpol  cpha  div     load   pat    loop  exp    busy
      vecs[0] = '{1'b0, 1'b0, 8'd0,   8'h3C, 8'hA5, 1'b0, 8'hA5, 18};
      vecs[1] = '{1'b1, 1'b1, 8'd3,   8'hF0, 8'h5A, 1'b0, 8'h5A, 69};
      vecs[2] = '{1'b0, 1'b1, 8'd1,   8'h81, 8'h00, 1'b1, 8'h81, 35};
      vecs[3] = '{1'b1, 1'b0, 8'd1,   8'h81, 8'h00, 1'b1, 8'h81, 35};
      vecs[4] = '{1'b0, 1'b0, 8'hFF,  8'hC3, 8'h96, 1'b0, 8'h96, 4353};
      vecs[5] = '{1'b1, 1'b0, 8'd2,   8'h55, 8'h3C, 1'b0, 8'h3C, 52};

      bus.start = 1'b0; bus.abort = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.clk_div = '0;
      cur_cpol = 1'b0; cur_cpha = 1'b0; cur_div = 0; load_val = '0; slv_pat = '0;
      loopback = 1'b0; prev_busy = 1'b0; prev_sck = 1'b0; slv_bit = 1'b0;
      edges = 0; edge_total = 0; cyc = 0; last_edge = 0; excl_bad = 0;
      busy_cnt = 0; shift_cnt = 0; load_cnt = 0; bad_gap = 0; rx = '0;

      repeat (3) tick();
      check("reset_outputs", outs(), 9'b000000001);
      n_rst = 1'b1;
      tick();
      check("post_reset_idle", outs(), 9'b000000001);

      for (int i = 0; i < 6; i++) run_vector(vecs[i], 1'b0);

      // start during XFER must not disturb the transfer
      run_vector(vecs[1], 1'b1);

      // abort at edge 5, mode 3
      v = '{1'b1, 1'b1, 8'd1, 8'h3C, 8'hA5, 1'b0, 8'h00, 0};
      set_mode(v);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      wait_edges(5);
      check("pre_abort_sck", bus.sck, 1'b0);
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
      check("abort_outputs", outs() & 9'b111111011, 9'b000001011);
      tick();
      check("abort_clear_pulse", bus.shift_clear, 0);
      check("abort_sr_cleared", sr, 0);
      repeat (40) tick();
      check("abort_stays_idle", bus.busy, 0);
      run_vector(vecs[0], 1'b0);

      // start and abort together in IDLE
      bus.start = 1'b1; bus.abort = 1'b1; tick();
      bus.start = 1'b0; bus.abort = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.busy || bus.load_enable || !bus.ss_n) seen++;
         tick();
      end
      check("start_abort_ignored", seen, 0);

      // reset mid-transfer with captured cpol=1
      v = '{1'b1, 1'b0, 8'd2, 8'h00, 8'hFF, 1'b0, 8'h00, 0};
      set_mode(v);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      wait_edges(3);
      check("pre_reset_serial_in", bus.serial_in, 1);
      n_rst = 1'b0; tick();
      check("reset_mid_xfer", outs(), 9'b000000001);
      n_rst = 1'b1;
      repeat (60) tick();
      check("reset_stays_idle", outs(), 9'b000000001);
      run_vector(vecs[2], 1'b0);

      check("exclusive_strobes", excl_bad, 0);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
